// File: rtl/prm_edge_pkg.sv
// Shared types for the PRM edge-mask accumulation stage: obstacle code width,
// code type and the accumulator state encoding.
package prm_edge_pkg;

   localparam int CODE_W = 15;

   typedef logic [CODE_W-1:0] obs_code_t;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DRAIN,
      REPORT
   } prm_acc_state_t;

endpackage

// File: rtl/prm_obs_code_stage.sv
// Accept register: captures an accepted obstacle code and presents it, with a
// one-cycle live flag, to every edge checker.
module prm_obs_code_stage
   import prm_edge_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      clr,
   input  logic      load,
   input  obs_code_t code,
   output obs_code_t obs_code,
   output logic      obs_vld
);

   // The code holds between beats so checkers see a stable input; only the
   // live flag drops when nothing was accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         obs_code <= '0;
         obs_vld  <= 1'b0;
      end else if (clr) begin
         obs_vld  <= 1'b0;
      end else if (load) begin
         obs_code <= code;
         obs_vld  <= 1'b1;
      end else begin
         obs_vld  <= 1'b0;
      end
   end

endmodule

// File: rtl/prm_edge_mask_accum.sv
// Sticky-ORs per-edge checker masks over a framed obstacle stream and reports
// the blocked-edge bitmap. Optional obstacle counter: PRM_OBS_COUNT_EN.
module prm_edge_mask_accum
   import prm_edge_pkg::*;
#(
   parameter int NUM_EDGES = 64
`ifdef PRM_OBS_COUNT_EN
   ,
   parameter int CNT_W = 16
`endif
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  obs_code_t            s_code,
   input  logic                 s_last,
   input  logic                 clr,
   output obs_code_t            obs_code,
   output logic                 obs_vld,
   input  logic [NUM_EDGES-1:0] edge_mask_i,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [NUM_EDGES-1:0] m_blocked
`ifdef PRM_OBS_COUNT_EN
   ,
   output logic [CNT_W-1:0]     m_obs_cnt
`endif
);

   prm_acc_state_t       state;
   prm_acc_state_t       state_next;
   logic                 armed;
   logic                 accept;
   logic                 report_done;
   logic [NUM_EDGES-1:0] blocked;

   // armed keeps s_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed <= 1'b0;
         state <= IDLE;
      end else begin
         armed <= 1'b1;
         state <= state_next;
      end
   end

   assign s_ready     = armed && !clr && ((state == IDLE) || (state == ACCUM));
   assign accept      = s_valid && s_ready;
   assign m_valid     = (state == REPORT) && !clr;
   assign report_done = m_valid && m_ready;
   assign m_blocked   = blocked;

   always_comb begin
      state_next = state;
      if (clr) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (accept) state_next = s_last ? DRAIN : ACCUM;
            ACCUM:   if (accept && s_last) state_next = DRAIN;
            DRAIN:   state_next = REPORT;
            REPORT:  if (report_done) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   prm_obs_code_stage u_code_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .load     (accept),
      .code     (s_code),
      .obs_code (obs_code),
      .obs_vld  (obs_vld)
   );

   // Mask path kept to a single AND/OR so the checker bank owns the cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blocked <= '0;
      end else if (clr || report_done) begin
         blocked <= '0;
      end else if (obs_vld) begin
         blocked <= blocked | edge_mask_i;
      end
   end

`ifdef PRM_OBS_COUNT_EN
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;

   assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

   // The published count includes the last beat, so latch the incremented value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         m_obs_cnt <= '0;
      end else if (clr || report_done) begin
         cnt       <= '0;
         m_obs_cnt <= '0;
      end else if (accept) begin
         cnt <= cnt_inc;
         if (s_last) m_obs_cnt <= cnt_inc;
      end
   end
`endif

endmodule

// File: tb/tb_prm_edge_mask_accum.sv
// Directed bench for prm_edge_mask_accum with a 4-edge lookup-table checker stub.
// Counter checks run only when PRM_OBS_COUNT_EN is defined (CNT_W = 2).
module tb_prm_edge_mask_accum;
   import prm_edge_pkg::*;

   localparam int NE = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          s_valid;
   logic          s_ready;
   obs_code_t     s_code;
   logic          s_last;
   logic          clr;
   obs_code_t     obs_code;
   logic          obs_vld;
   logic [NE-1:0] edge_mask;
   logic          m_valid;
   logic          m_ready;
   logic [NE-1:0] m_blocked;
`ifdef PRM_OBS_COUNT_EN
   logic [1:0]    m_obs_cnt;
`endif

   int check_count = 0;
   int error_count = 0;

   always #5 clk = ~clk;

   prm_edge_mask_accum #(
      .NUM_EDGES (NE)
`ifdef PRM_OBS_COUNT_EN
      ,
      .CNT_W     (2)
`endif
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_code      (s_code),
      .s_last      (s_last),
      .clr         (clr),
      .obs_code    (obs_code),
      .obs_vld     (obs_vld),
      .edge_mask_i (edge_mask),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_blocked   (m_blocked)
`ifdef PRM_OBS_COUNT_EN
      ,
      .m_obs_cnt   (m_obs_cnt)
`endif
   );

   // Checker stub; drives junk while obs_vld is low since the DUT must ignore it.
   always_comb begin
      edge_mask = 4'b1111;
      if (obs_vld) begin
         case (obs_code)
            15'h0001: edge_mask = 4'b0001;
            15'h4000: edge_mask = 4'b0100;
            15'h7FFF: edge_mask = 4'b0000;
            15'h1234: edge_mask = 4'b1000;
            15'h0042: edge_mask = 4'b0010;
            15'h0011: edge_mask = 4'b1111;
            15'h0022: edge_mask = 4'b1101;
            default:  edge_mask = 4'b0000;
         endcase
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one beat, waits (bounded) for s_ready, then lets the edge accept it.
   task automatic applyStimulus(input obs_code_t code, input logic last);
      int budget;
      s_valid = 1'b1;
      s_code  = code;
      s_last  = last;
      budget  = 0;
      while (!s_ready && budget < 20) begin
         step();
         budget++;
      end
      if (!s_ready) checkOutput("ready_timeout", 32'(s_ready), 32'd1);
      step();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic handshake();
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
   endtask

   initial begin
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_code  = '0;
      s_last  = 1'b0;
      clr     = 1'b0;
      m_ready = 1'b0;

      repeat (2) step();
      checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
      checkOutput("rst_obs_code", 32'(obs_code), 32'd0);
      checkOutput("rst_obs_vld", 32'(obs_vld), 32'd0);
      checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
      checkOutput("rst_m_blocked", 32'(m_blocked), 32'd0);
`ifdef PRM_OBS_COUNT_EN
      checkOutput("rst_m_obs_cnt", 32'(m_obs_cnt), 32'd0);
`endif
      rst_n = 1'b1;
      #1;
      checkOutput("ready_before_edge", 32'(s_ready), 32'd0);
      step();
      checkOutput("ready_after_edge", 32'(s_ready), 32'd1);
      step();
      checkOutput("idle_blocked_gated", 32'(m_blocked), 32'd0);

      // Three-beat frame, back to back
      applyStimulus(15'h0001, 1'b0);
      checkOutput("f1_obs_vld", 32'(obs_vld), 32'd1);
      checkOutput("f1_obs_code0", 32'(obs_code), 32'h0001);
      applyStimulus(15'h4000, 1'b0);
      checkOutput("f1_obs_code1", 32'(obs_code), 32'h4000);
      applyStimulus(15'h7FFF, 1'b1);
      checkOutput("f1_drain_ready", 32'(s_ready), 32'd0);
      checkOutput("f1_drain_valid", 32'(m_valid), 32'd0);
      checkOutput("f1_obs_code2", 32'(obs_code), 32'h7FFF);
      step();
      checkOutput("f1_m_valid", 32'(m_valid), 32'd1);
      checkOutput("f1_m_blocked", 32'(m_blocked), 32'b0101);
`ifdef PRM_OBS_COUNT_EN
      checkOutput("f1_m_obs_cnt", 32'(m_obs_cnt), 32'd3);
`endif
      for (int i = 0; i < 5; i++) begin
         step();
         checkOutput("hold_m_valid", 32'(m_valid), 32'd1);
         checkOutput("hold_m_blocked", 32'(m_blocked), 32'b0101);
         checkOutput("hold_s_ready", 32'(s_ready), 32'd0);
      end

      // Next frame offered during the handshake cycle must wait one cycle
      s_valid = 1'b1;
      s_code  = 15'h1234;
      s_last  = 1'b1;
      m_ready = 1'b1;
      #1;
      checkOutput("hs_s_ready", 32'(s_ready), 32'd0);
      step();
      m_ready = 1'b0;
      checkOutput("post_hs_m_valid", 32'(m_valid), 32'd0);
      checkOutput("post_hs_blocked", 32'(m_blocked), 32'd0);
      checkOutput("post_hs_obs_vld", 32'(obs_vld), 32'd0);
      checkOutput("post_hs_s_ready", 32'(s_ready), 32'd1);
      step();
      s_valid = 1'b0;
      s_last  = 1'b0;
      checkOutput("f2_obs_vld", 32'(obs_vld), 32'd1);
      checkOutput("f2_obs_code", 32'(obs_code), 32'h1234);
      step();
      checkOutput("f2_m_valid", 32'(m_valid), 32'd1);
      checkOutput("f2_m_blocked", 32'(m_blocked), 32'b1000);
`ifdef PRM_OBS_COUNT_EN
      checkOutput("f2_m_obs_cnt", 32'(m_obs_cnt), 32'd1);
`endif
      handshake();

      // Abort after two beats; nothing from them may leak into the next report
      applyStimulus(15'h0011, 1'b0);
      applyStimulus(15'h0022, 1'b0);
      clr = 1'b1;
      #1;
      checkOutput("clr_s_ready", 32'(s_ready), 32'd0);
      step();
      clr = 1'b0;
      checkOutput("clr_obs_vld", 32'(obs_vld), 32'd0);
      checkOutput("clr_blocked", 32'(m_blocked), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput("clr_no_valid", 32'(m_valid), 32'd0);
      end
      applyStimulus(15'h0042, 1'b1);
      step();
      checkOutput("f3_m_valid", 32'(m_valid), 32'd1);
      checkOutput("f3_m_blocked", 32'(m_blocked), 32'b0010);
`ifdef PRM_OBS_COUNT_EN
      checkOutput("f3_m_obs_cnt", 32'(m_obs_cnt), 32'd1);
`endif
      handshake();

      // Five-beat frame drives the 2-bit counter into saturation
      applyStimulus(15'h0001, 1'b0);
      applyStimulus(15'h4000, 1'b0);
      applyStimulus(15'h7FFF, 1'b0);
      applyStimulus(15'h1234, 1'b0);
      applyStimulus(15'h0042, 1'b1);
      step();
      checkOutput("f4_m_valid", 32'(m_valid), 32'd1);
      checkOutput("f4_m_blocked", 32'(m_blocked), 32'b1111);
`ifdef PRM_OBS_COUNT_EN
      checkOutput("f4_m_obs_cnt_sat", 32'(m_obs_cnt), 32'd3);
`endif
      handshake();

      // Asynchronous reset mid-frame
      applyStimulus(15'h0001, 1'b0);
      applyStimulus(15'h4000, 1'b0);
      checkOutput("pre_rst_blocked", 32'(m_blocked), 32'b0001);
      checkOutput("pre_rst_obs_vld", 32'(obs_vld), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_s_ready", 32'(s_ready), 32'd0);
      checkOutput("arst_obs_code", 32'(obs_code), 32'd0);
      checkOutput("arst_obs_vld", 32'(obs_vld), 32'd0);
      checkOutput("arst_m_valid", 32'(m_valid), 32'd0);
      checkOutput("arst_m_blocked", 32'(m_blocked), 32'd0);
`ifdef PRM_OBS_COUNT_EN
      checkOutput("arst_m_obs_cnt", 32'(m_obs_cnt), 32'd0);
`endif
      step();
      rst_n = 1'b1;
      step();
      checkOutput("rerst_s_ready", 32'(s_ready), 32'd1);

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
